cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 93 +++++++++
 tb/tb_cacheline_adaptor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory burst adaptor: splits one line read/write into
// width/burst_width beats, each beat paced by the memory's resp_i.
module cacheline_adaptor #(
  parameter int width       = 256,
  parameter int burst_width = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [width-1:0]       line_i,
  output logic [width-1:0]       line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [burst_width-1:0] burst_i,
  output logic [burst_width-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int beats = width / burst_width;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam int off_w = $clog2(width / 8);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [cnt_w-1:0]       cnt_reg;
  logic [width-1:0]       wline_reg;
  logic [burst_width-1:0] wlane [beats];
  logic                   accept;
  logic                   last_accept;

  generate
    for (genvar gi = 0; gi < beats; gi++) begin : g_lane
      assign wlane[gi] = wline_reg[gi*burst_width +: burst_width];
    end
  endgenerate

  assign accept      = resp_i && (state_reg == READ || state_reg == WRITE);
  assign last_accept = accept && (cnt_reg == last_beat);

  // Write has priority over read when both are requested together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (write_i) state_next = WRITE;
                   else if (read_i) state_next = READ;
      READ, WRITE: if (last_accept) state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Outputs are registered from the next state so read_o/write_o/resp_o
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      wline_reg <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      read_o  <= (state_next == READ);
      write_o <= (state_next == WRITE);
      resp_o  <= (state_next == DONE);
      if (state_reg == IDLE && state_next != IDLE) begin
        cnt_reg   <= '0;
        address_o <= {address_i[31:off_w], off_w'(0)};
        if (write_i) begin
          wline_reg <= line_i;
          burst_o   <= line_i[burst_width-1:0];
        end
      end else if (accept && !last_accept) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (state_reg == WRITE) burst_o <= wlane[cnt_reg + 1'b1];
      end
      if (state_reg == READ && resp_i)
        line_o[cnt_reg*burst_width +: burst_width] <= burst_i;
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a memory responder serves/captures
// beats from a line-addressed memory model; a monitor checks each completion.
module tb_cacheline_adaptor;
  localparam int W     = 256;
  localparam int BW    = 64;
  localparam int BEATS = W / BW;

  logic          clk, reset_n;
  logic [W-1:0]  line_i, line_o;
  logic [31:0]   address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;

  cacheline_adaptor #(.width(W), .burst_width(BW)) dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 1 = read, 2 = write
  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [W-1:0] line;
    int           issue_cyc;
    int           exp_lat;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  mem [logic [31:0]];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rsp_mode = 0;   // 0 random, 1 always accept, 2 fixed stall pattern
  int            pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int            cap_kind = 0;
  logic [W-1:0]  cap_line = '0;

  function automatic logic [W-1:0] mem_read(input logic [31:0] a);
    logic [W-1:0] l;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < W/32; i++) l[i*32 +: 32] = a * 32'h9E37_79B9 + 32'(i) * 32'h0101_0101;
    return l;
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int i = 0; i < W/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory-side responder: decides resp_i each cycle, serves read beats from
  // the memory model and records write beats as they are accepted.
  initial begin
    logic [W-1:0] src;
    int  beat, pidx;
    bit  active, rsp;
    beat = 0; pidx = 0; active = 0;
    resp_i = 1'b0; burst_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!read_o && !write_o) begin
        active  = 0;
        resp_i  = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom};
      end else begin
        if (!active) begin
          active   = 1; beat = 0; pidx = 0;
          cap_kind = read_o ? (write_o ? 3 : 1) : 2;
          cap_line = '0;
        end
        case (rsp_mode)
          1:       rsp = 1;
          2:       rsp = (pidx < 7) ? (pat[pidx] != 0) : 1;
          default: rsp = ($urandom_range(0, 3) != 0);
        endcase
        pidx++;
        resp_i  = rsp;
        burst_i = {$urandom, $urandom};
        if (rsp && beat < BEATS) begin
          if (read_o) begin
            src     = mem_read(address_o);
            burst_i = src[beat*BW +: BW];
          end
          if (write_o) cap_line[beat*BW +: BW] = burst_o;
          beat++;
        end
      end
    end
  end

  // Monitor: reset values, one completion per expectation, line_o hold.
  initial begin
    exp_t         e;
    logic         rst_seen;
    logic [W-1:0] last_read;
    last_read = '0;
    forever begin
      @(posedge clk);
      rst_seen = reset_n;
      @(negedge clk);
      if (!rst_seen) begin
        chk("reset_ctrl", W'({resp_o, read_o, write_o, address_o}), '0);
        chk("reset_burst_o", W'(burst_o), '0);
        chk("reset_line_o", line_o, '0);
        last_read = '0;
      end else begin
        if (read_o || write_o) chk("rd_wr_exclusive", W'(read_o & write_o), '0);
        if (resp_o) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got resp_o=1 at cycle %0d, required no response", cyc);
          end else begin
            e = sb.pop_front();
            chk("address_o", W'(address_o), W'(e.addr));
            chk("txn_kind", W'(cap_kind), W'(e.kind));
            if (e.kind == 1) begin
              chk("read_line", line_o, e.line);
              last_read = e.line;
            end else begin
              chk("write_beats", cap_line, e.line);
            end
            if (e.exp_lat > 0) chk("latency", W'(cyc - e.issue_cyc + 1), W'(e.exp_lat));
          end
        end else if (!read_o) begin
          chk("line_o_hold", line_o, last_read);
        end
      end
    end
  end

  // kind: 1 read, 2 write, 3 both requested (write expected)
  task automatic issue(input int kind, input logic [31:0] a, input logic [W-1:0] l, input int lat);
    exp_t e;
    read_i    = (kind != 2);
    write_i   = (kind != 1);
    address_i = a;
    line_i    = l;
    e.kind      = (kind == 1) ? 1 : 2;
    e.addr      = a & ~32'h1F;
    e.line      = (kind == 1) ? mem_read(e.addr) : l;
    e.issue_cyc = cyc;
    e.exp_lat   = lat;
    if (kind != 1) mem[e.addr] = l;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit junk);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      read_i    = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      write_i   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      address_i = $urandom;
      line_i    = rand_line();
    end while (!resp_o && n < 100);
    if (!resp_o) begin
      checks++; errors++;
      $display("FAIL timeout: resp_o not seen after %0d cycles, required within 100", n);
      read_i = 1'b0; write_i = 1'b0;
      reset_n = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
  endtask

  task automatic idle_cycle(input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < gap; i++) begin
      read_i = 1'b0; write_i = 1'b0;
      address_i = $urandom; line_i = rand_line();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int           k;
    logic [31:0]  a;
    reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0;
    address_i = '0; line_i = '0;
    repeat (3) @(posedge clk);
    #1;

    // Directed read in the first cycle out of reset, continuous beats.
    mem[32'h0000_1220] = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    rsp_mode = 1;
    reset_n  = 1'b1;
    issue(1, 32'h0000_1234, '0, 6);
    wait_done(0);

    // Directed write with stalls; junk on the cache side throughout.
    idle_cycle(1);
    rsp_mode = 2;
    issue(2, 32'h0000_2468,
          256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 9);
    wait_done(1);

    // Read and write requested together: write only.
    idle_cycle(0);
    rsp_mode = 1;
    issue(3, 32'h0000_3333, rand_line(), 6);
    wait_done(1);

    // Reset after two read beats, then a fresh read on the first live cycle.
    idle_cycle(1);
    issue(1, 32'h0000_4000, '0, 0);
    repeat (3) begin @(posedge clk); #1; end
    read_i = 1'b0; write_i = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(1, 32'h0000_4000, '0, 6);
    wait_done(0);

    // Randomised traffic over a small set of lines.
    rsp_mode = 0;
    for (int t = 0; t < 40; t++) begin
      idle_cycle($urandom_range(0, 2));
      k = $urandom_range(1, 3);
      a = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 5) | ($urandom & 32'h1F);
      issue(k, a, rand_line(), 0);
      wait_done(1'($urandom_range(0, 1)));
    end

    idle_cycle(3);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
